// File: rtl/led_ws2812_ser.sv
// WS2812 serializer: expands 4-bit zone means to {m,m} GRB words and drives the
// single-wire protocol, with a one-deep pending buffer for frames requested while busy.
module led_ws2812_ser #(
    parameter int LED_NUM = 16,
    parameter int T0H     = 30,
    parameter int T1H     = 60,
    parameter int TBIT    = 94,
    parameter int TRST    = 3750
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [4*LED_NUM-1:0] MeanR,
    input  logic [4*LED_NUM-1:0] MeanG,
    input  logic [4*LED_NUM-1:0] MeanB,
    output logic                 led_dout,
    output logic                 busy_o,
    output logic                 done_o
);
    // state | meaning
    // IDLE  | waiting for start_i
    // SEND  | shifting LED_NUM x 24 bits, TBIT cycles each
    // GAP   | TRST-cycle latch-low gap
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam int CW = $clog2(TBIT + 1);
    localparam int LW = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
    localparam int GW = $clog2(TRST + 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(TBIT - 1);
    localparam logic [CW-1:0] HI1_MIN  = CW'(TBIT - 1 - T1H);
    localparam logic [CW-1:0] HI0_MIN  = CW'(TBIT - 1 - T0H);
    localparam logic [LW-1:0] LED_LAST = LW'(LED_NUM - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TRST - 1);
    localparam logic [4:0]    BIT_TOP  = 5'd23;

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [4:0]    bit_q, bit_d;
    logic [LW-1:0] led_q, led_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          pend_q, pend_d;
    logic          dout_q, dout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [3:0] sh_r_q [LED_NUM];
    logic [3:0] sh_g_q [LED_NUM];
    logic [3:0] sh_b_q [LED_NUM];
    logic [3:0] sh_r_d [LED_NUM];
    logic [3:0] sh_g_d [LED_NUM];
    logic [3:0] sh_b_d [LED_NUM];
    logic [3:0] pb_r_q [LED_NUM];
    logic [3:0] pb_g_q [LED_NUM];
    logic [3:0] pb_b_q [LED_NUM];
    logic [3:0] pb_r_d [LED_NUM];
    logic [3:0] pb_g_d [LED_NUM];
    logic [3:0] pb_b_d [LED_NUM];
    logic [3:0] in_r [LED_NUM];
    logic [3:0] in_g [LED_NUM];
    logic [3:0] in_b [LED_NUM];

    logic        load, load_from_pb, capture;
    logic [3:0]  cur_r, cur_g, cur_b;
    logic [23:0] cur_word;
    logic        cur_bit;

    always_comb begin
        for (int i = 0; i < LED_NUM; i++) begin
            in_r[i] = MeanR[4*i +: 4];
            in_g[i] = MeanG[4*i +: 4];
            in_b[i] = MeanB[4*i +: 4];
        end
    end

    always_comb begin
        cur_r    = sh_r_q[led_q];
        cur_g    = sh_g_q[led_q];
        cur_b    = sh_b_q[led_q];
        cur_word = {cur_g, cur_g, cur_r, cur_r, cur_b, cur_b};
        cur_bit  = cur_word[bit_q];
    end

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        bit_d        = bit_q;
        led_d        = led_q;
        gap_d        = gap_q;
        pend_d       = pend_q;
        load         = 1'b0;
        load_from_pb = 1'b0;
        capture      = 1'b0;
        sh_r_d       = sh_r_q;
        sh_g_d       = sh_g_q;
        sh_b_d       = sh_b_q;
        pb_r_d       = pb_r_q;
        pb_g_d       = pb_g_q;
        pb_b_d       = pb_b_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SEND;
                    load    = 1'b1;
                end
            end
            SEND: begin
                if (start_i) begin
                    pend_d  = 1'b1;
                    capture = 1'b1;
                end
                if (cyc_q == '0) begin
                    cyc_d = CYC_LAST;
                    if (bit_q == '0) begin
                        bit_d = BIT_TOP;
                        if (led_q == LED_LAST) begin
                            state_d = GAP;
                            gap_d   = GAP_LAST;
                            led_d   = '0;
                        end else begin
                            led_d = led_q + 1'b1;
                        end
                    end else begin
                        bit_d = bit_q - 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q - 1'b1;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    // A start on the final gap cycle is treated as pending and sent directly.
                    if (pend_q || start_i) begin
                        state_d      = SEND;
                        load         = 1'b1;
                        load_from_pb = !start_i;
                        pend_d       = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q - 1'b1;
                    if (start_i) begin
                        pend_d  = 1'b1;
                        capture = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            cyc_d = CYC_LAST;
            bit_d = BIT_TOP;
            led_d = '0;
            for (int i = 0; i < LED_NUM; i++) begin
                sh_r_d[i] = load_from_pb ? pb_r_q[i] : in_r[i];
                sh_g_d[i] = load_from_pb ? pb_g_q[i] : in_g[i];
                sh_b_d[i] = load_from_pb ? pb_b_q[i] : in_b[i];
            end
        end
        if (capture) begin
            pb_r_d = in_r;
            pb_g_d = in_g;
            pb_b_d = in_b;
        end

        // cyc counts down; the bit is high while the remaining count is above its threshold.
        dout_d = (state_d == SEND) && (cyc_d > (cur_bit ? HI1_MIN : HI0_MIN));
        busy_d = (state_d != IDLE);
        done_d = (state_d == GAP) && (gap_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            led_q   <= '0;
            gap_q   <= '0;
            pend_q  <= 1'b0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < LED_NUM; i++) begin
                sh_r_q[i] <= '0;
                sh_g_q[i] <= '0;
                sh_b_q[i] <= '0;
                pb_r_q[i] <= '0;
                pb_g_q[i] <= '0;
                pb_b_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            led_q   <= led_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sh_r_q  <= sh_r_d;
            sh_g_q  <= sh_g_d;
            sh_b_q  <= sh_b_d;
            pb_r_q  <= pb_r_d;
            pb_g_q  <= pb_g_d;
            pb_b_q  <= pb_b_d;
        end
    end

    assign led_dout = dout_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_led_ws2812_ser.sv
// Directed bench for led_ws2812_ser with shortened timing parameters; all stimulus
// and sampling happen on the falling clock edge.
module tb_led_ws2812_ser;
    localparam int LN   = 3;
    localparam int T0H  = 3;
    localparam int T1H  = 7;
    localparam int TBIT = 11;
    localparam int TRST = 25;
    localparam int MW   = 4 * LN;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [MW-1:0] mean_r, mean_g, mean_b;
    logic          led_dout, busy_o, done_o;
    int            checks = 0;
    int            errors = 0;
    logic [7:0]    dec_bytes [LN*3];
    logic          idle_bad;

    always #5 clk = ~clk;

    led_ws2812_ser #(
        .LED_NUM(LN), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRST(TRST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .MeanR(mean_r), .MeanG(mean_g), .MeanB(mean_b),
        .led_dout(led_dout), .busy_o(busy_o), .done_o(done_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input string tag, input logic [MW-1:0] r, g, b);
        mean_r = r; mean_g = g; mean_b = b; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; mean_r = ~r; mean_g = ~g; mean_b = ~b;
        chk({tag, "_lat_dout"}, 32'(led_dout), 32'd1);
        chk({tag, "_lat_busy"}, 32'(busy_o), 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [MW-1:0] r, g, b,
                               input int inj_bit, input logic [MW-1:0] nr, ng, nb);
        logic [23:0] w;
        int          hi, gb;
        logic        shape_bad, busy_bad, done_seen;
        busy_bad = 1'b0; done_seen = 1'b0;
        for (int l = 0; l < LN; l++) begin
            w = {g[4*l +: 4], g[4*l +: 4], r[4*l +: 4], r[4*l +: 4], b[4*l +: 4], b[4*l +: 4]};
            for (int k = 23; k >= 0; k--) begin
                hi = 0; shape_bad = 1'b0; gb = l * 24 + (23 - k);
                for (int c = 0; c < TBIT; c++) begin
                    if (led_dout === 1'b1) begin
                        hi++;
                        if (c != hi - 1) shape_bad = 1'b1;
                    end
                    if (busy_o !== 1'b1) busy_bad = 1'b1;
                    if (done_o !== 1'b0) done_seen = 1'b1;
                    if (gb == inj_bit && c == 2) begin
                        mean_r = nr; mean_g = ng; mean_b = nb; start_i = 1'b1;
                    end
                    @(negedge clk);
                    if (start_i) begin
                        start_i = 1'b0; mean_r = ~nr; mean_g = ~ng; mean_b = ~nb;
                    end
                end
                chk($sformatf("%s_bit%0d_high", tag, gb), 32'(hi), 32'(w[k] ? T1H : T0H));
                chk($sformatf("%s_bit%0d_shape", tag, gb), 32'(shape_bad), 32'd0);
                dec_bytes[l*3 + (23-k)/8][k%8] = (hi > (T0H + T1H) / 2);
            end
        end
        chk({tag, "_busy_in_send"}, 32'(busy_bad), 32'd0);
        chk({tag, "_done_in_send"}, 32'(done_seen), 32'd0);
    endtask

    task automatic check_gap(input string tag, input logic expect_send, input logic start_last,
                             input logic [MW-1:0] nr, ng, nb);
        int   low_cnt, done_cnt, done_pos;
        logic busy_bad;
        low_cnt = 0; done_cnt = 0; done_pos = -1; busy_bad = 1'b0;
        for (int c = 0; c < TRST; c++) begin
            if (led_dout === 1'b0) low_cnt++;
            if (busy_o !== 1'b1) busy_bad = 1'b1;
            if (done_o === 1'b1) begin done_cnt++; done_pos = c; end
            if (start_last && c == TRST - 1) begin
                mean_r = nr; mean_g = ng; mean_b = nb; start_i = 1'b1;
            end
            @(negedge clk);
            if (start_i) begin
                start_i = 1'b0; mean_r = ~nr; mean_g = ~ng; mean_b = ~nb;
            end
        end
        chk({tag, "_low_cycles"}, 32'(low_cnt), 32'(TRST));
        chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, "_done_pos"}, 32'(done_pos), 32'(TRST - 1));
        chk({tag, "_busy_in_gap"}, 32'(busy_bad), 32'd0);
        chk({tag, "_after_dout"}, 32'(led_dout), 32'(expect_send));
        chk({tag, "_after_busy"}, 32'(busy_o), 32'(expect_send));
        chk({tag, "_after_done"}, 32'(done_o), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0;
        mean_r = '0; mean_g = '0; mean_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_dout", 32'(led_dout), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy_o), 32'd0);

        start_frame("zero", '0, '0, '0);
        check_frame("zero", '0, '0, '0, -1, '0, '0, '0);
        check_gap("zero_gap", 1'b0, 1'b0, '0, '0, '0);

        @(negedge clk);
        start_frame("ones", {MW{1'b1}}, {MW{1'b1}}, {MW{1'b1}});
        check_frame("ones", {MW{1'b1}}, {MW{1'b1}}, {MW{1'b1}}, -1, '0, '0, '0);
        check_gap("ones_gap", 1'b0, 1'b0, '0, '0, '0);

        start_frame("zone", 12'h001, 12'h002, 12'h003);
        check_frame("zone", 12'h001, 12'h002, 12'h003, -1, '0, '0, '0);
        chk("zone_byte0", 32'(dec_bytes[0]), 32'h22);
        chk("zone_byte1", 32'(dec_bytes[1]), 32'h11);
        chk("zone_byte2", 32'(dec_bytes[2]), 32'h33);
        for (int i = 3; i < LN * 3; i++)
            chk($sformatf("zone_byte%0d", i), 32'(dec_bytes[i]), 32'h00);
        check_gap("zone_gap", 1'b0, 1'b0, '0, '0, '0);

        start_frame("mix", 12'h5A3, 12'hF0C, 12'h69E);
        check_frame("mix", 12'h5A3, 12'hF0C, 12'h69E, -1, '0, '0, '0);
        chk("mix_byte3", 32'(dec_bytes[3]), 32'h00);
        chk("mix_byte4", 32'(dec_bytes[4]), 32'hAA);
        chk("mix_byte5", 32'(dec_bytes[5]), 32'h99);
        chk("mix_byte6", 32'(dec_bytes[6]), 32'hFF);
        check_gap("mix_gap", 1'b0, 1'b0, '0, '0, '0);

        start_frame("ms1", 12'h123, 12'h456, 12'h789);
        check_frame("ms1", 12'h123, 12'h456, 12'h789, 30, 12'hC3D, 12'h0E7, 12'hB18);
        check_gap("ms1_gap", 1'b1, 1'b0, '0, '0, '0);
        check_frame("ms2", 12'hC3D, 12'h0E7, 12'hB18, -1, '0, '0, '0);
        check_gap("ms2_gap", 1'b0, 1'b0, '0, '0, '0);

        start_frame("lg1", 12'h2F1, 12'h8A0, 12'h3C5);
        check_frame("lg1", 12'h2F1, 12'h8A0, 12'h3C5, -1, '0, '0, '0);
        check_gap("lg1_gap", 1'b1, 1'b1, 12'h9E4, 12'h17B, 12'hD06);
        check_frame("lg2", 12'h9E4, 12'h17B, 12'hD06, -1, '0, '0, '0);
        check_gap("lg2_gap", 1'b0, 1'b0, '0, '0, '0);

        start_frame("rst", {MW{1'b1}}, 12'hA5A, 12'h0F0);
        repeat (40 * TBIT + 2) @(negedge clk);
        chk("rst_pre_dout", 32'(led_dout), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_dout", 32'(led_dout), 32'd0);
        chk("rst_async_busy", 32'(busy_o), 32'd0);
        chk("rst_async_done", 32'(done_o), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (led_dout !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) idle_bad = 1'b1;
        end
        chk("rst_no_resume", 32'(idle_bad), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start_frame("post", 12'h7B2, 12'h1E9, 12'h64C);
        check_frame("post", 12'h7B2, 12'h1E9, 12'h64C, -1, '0, '0, '0);
        check_gap("post_gap", 1'b0, 1'b0, '0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
